sevseg_scan_ctrl: RTL and testbench
===================================

# sevseg_scan_ctrl

Wishbone-programmable scan scheduler for the eight-digit seven-segment display on the SweRVolf peripheral bus. It time-multiplexes the shared segment bus across eight active-low anodes and inserts a blanking tick between digits to suppress ghosting. Per-digit on-time is PWM-trimmed by a 4-bit brightness field. Digit and enable data are double-buffered and take effect only at frame boundaries, so software updates never tear a frame.

## Interface
Parameters:
- `DEFAULT_DIV`, 16'd999: reset value of the scan prescaler. One tick every DIV+1 clocks.

Ports:
- `i_clk`  in  1  clock. Single clock; all logic is in this domain.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_wb_adr`  in  4  byte address; bits [3:2] select the register.
- `i_wb_dat`  in  32  write data.
- `i_wb_sel`  in  4  byte lanes.
- `i_wb_we`  in  1  write enable.
- `i_wb_cyc`  in  1  cycle.
- `i_wb_stb`  in  1  strobe.
- `o_wb_rdt`  out  32  read data, registered.
- `o_wb_ack`  out  1  acknowledge.
- `o_an`  out  8  anodes, active-low.
- `o_seg`  out  7  segments {a,b,c,d,e,f,g}, active-low.
- `o_frame`  out  1  one-clock pulse at every frame wrap.

## Operation
- Registers (unwritten bits read 0; byte-lane writes honoured):
  - 0x0 CTRL: bit0 EN, bits[7:4] BRIGHT. Reset 0x000000F0.
  - 0x4 ENABLES[7:0]: bit i=1 displays digit i. Reset 0x00.
  - 0x8 DIGITS[31:0]: nibble i is the hex value of digit i. Reset 0.
  - 0xC DIV[15:0]: reset DEFAULT_DIV.
- Bus handshake:
  - `o_wb_ack <= i_wb_cyc & !o_wb_ack`.
  - A write takes effect when `cyc & stb & we & !ack`.
  - `o_wb_rdt` is loaded every clock from the register addressed by `adr[3:2]`.
- Prescaler:
  - A down-counter reloads DIV at 0 and asserts `tick` for one clock.
  - DIV=0 gives a tick every clock.
  - A DIV write takes effect at the next reload.
- Shadow registers:
  - ENABLES and DIGITS are staging registers; `sh_en` and `sh_dig` drive the display.
  - Copy staging to shadow on the frame wrap, and on the EN 0->1 transition.
- State machine (advances only on `tick`):
  - IDLE: EN=0. Hold digit=0, sub=0. Outputs blank.
  - EN rising: IDLE -> BLANK with digit=0, shadows loaded.
  - BLANK: lasts 1 tick (sub=0), then -> ON with sub=1.
  - ON: sub counts 1..15. At sub=15, -> BLANK with digit+1.
  - Wrap at digit 7 -> 0: reload shadows and pulse `o_frame` on that tick.
- Frame length: 8 slots x 16 ticks = 128 ticks.
- Output drive:
  - In ON, anode `digit` is driven low iff `sh_en[digit] & (sub <= BRIGHT)`.
  - BRIGHT=0 therefore gives a dark display that still scans and still pulses `o_frame`.
  - All other anodes are high.
- Segment data:
  - `o_seg` = hex decode of `sh_dig[4*digit +: 4]` whenever an anode is low; 7'h7F otherwise.
  - Encoding: 0=0000001, 1=1001111, 8=0000000, F=0111000.
- EN cleared at any time: on the next clock, state=IDLE, digit=0, sub=0, prescaler reloaded, outputs blank the clock after. Takes priority over a simultaneous tick.
- Simultaneous frame wrap and ENABLES/DIGITS write in the same clock: the shadow gets the pre-write staging value; the new value lands one frame later.

## Timing
- Reset values:
  - `o_an`=8'hFF, `o_seg`=7'h7F, `o_frame`=0, `o_wb_ack`=0, `o_wb_rdt`=0.
  - state=IDLE, prescaler=DEFAULT_DIV.
- Outputs are registered from (state, digit, sub, shadows) with 1 clock latency after the state update.
- Read data is valid in the same clock that `o_wb_ack` is high.
- Asserting `i_rst` mid-frame blanks the outputs immediately (asynchronously) and restores every register to its reset value.

## Structure
- Shared package `sevseg_pkg`:
  - state enum IDLE/BLANK/ON.
  - register offsets CTRL/ENABLES/DIGITS/DIV.
  - `SLOT_TICKS`=16 and `NUM_DIGITS`=8.
- One sub-module: `sevseg_hex_dec` (4-bit value -> 7-bit active-low segments, combinational).

## Test plan
- Reset: assert `i_rst` -> `o_an`=FF, `o_seg`=7F; reads return CTRL=0x000000F0, DIV=DEFAULT_DIV.
- Full brightness: DIV=0, DIGITS=0x76543210, ENABLES=0xFF, CTRL=0xF1 ->
  - slot 0 shows 1 clock `o_an`=FF, then 15 clocks `o_an`=FE with `o_seg`=0000001;
  - slot 7 drives `o_an`=7F;
  - `o_frame` pulses every 128 clocks.
- Dimmed, sparse digits: CTRL=0x41, ENABLES=0x05 ->
  - each of digits 0 and 2 is low for exactly 4 of 16 clocks;
  - digits 1 and 3..7 never go low.
- Tear-free update: write DIGITS=0x88888888 mid-frame -> old digit values persist until the `o_frame` pulse; the following frame shows `o_seg`=0000000.
- Disable mid-slot: clear EN during ON -> `o_an`=FF within 2 clocks; setting EN again restarts at digit 0 with a BLANK tick.
- Prescaler and async reset: DIV=3 -> one slot lasts 64 clocks; asserting `i_rst` mid-slot blanks outputs with no clock edge.

Source files
------------

// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - shared types and constants for the seven-segment scan controller
// Purpose: scan state enum, register offsets (adr[3:2]) and scan geometry.
// Ports: none (package).
package sevseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_t;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_ENABLES = 2'd1;
  localparam logic [1:0] REG_DIGITS  = 2'd2;
  localparam logic [1:0] REG_DIV     = 2'd3;

  localparam int SLOT_TICKS = 16;
  localparam int NUM_DIGITS = 8;

  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);
  localparam logic [3:0] LAST_SUB   = 4'(SLOT_TICKS - 1);

endpackage

// File: rtl/sevseg_hex_dec.sv
// rtl/sevseg_hex_dec.sv - hex nibble to active-low seven-segment decoder
// Purpose: combinational decode of a 4-bit value to segments {a,b,c,d,e,f,g}, 0 = lit.
// Ports:
//   i_val  in  4  hex value
//   o_seg  out 7  active-low segments
module sevseg_hex_dec (
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_val)
      4'h0: o_seg = 7'b0000001;
      4'h1: o_seg = 7'b1001111;
      4'h2: o_seg = 7'b0010010;
      4'h3: o_seg = 7'b0000110;
      4'h4: o_seg = 7'b1001100;
      4'h5: o_seg = 7'b0100100;
      4'h6: o_seg = 7'b0100000;
      4'h7: o_seg = 7'b0001111;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0000100;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b1100000;
      4'hC: o_seg = 7'b0110001;
      4'hD: o_seg = 7'b1000010;
      4'hE: o_seg = 7'b0110000;
      4'hF: o_seg = 7'b0111000;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// rtl/sevseg_scan_ctrl.sv - Wishbone-programmable eight-digit seven-segment scan scheduler
// Purpose: time-multiplexes a shared segment bus over eight active-low anodes with a
//   blanking tick per digit, 4-bit PWM brightness and frame-synchronous shadow registers.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_wb_adr/dat/sel/we/cyc/stb  Wishbone slave inputs (adr[3:2] selects the register)
//   o_wb_rdt, o_wb_ack      registered read data and acknowledge
//   o_an                    anodes, active-low
//   o_seg                   segments {a..g}, active-low
//   o_frame                 one-clock pulse per frame wrap
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd999
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_frame
);

  // Register file (staging side)
  logic        r_en;
  logic [3:0]  r_bright;
  logic [7:0]  r_enables;
  logic [31:0] r_digits;
  logic [15:0] r_div;

  // Bus
  logic        r_ack;
  logic [31:0] r_rdt;

  // Display side
  logic [15:0] r_presc;
  state_t      r_state;
  logic [2:0]  r_digit;
  logic [3:0]  r_sub;
  logic [7:0]  r_sh_en;
  logic [31:0] r_sh_dig;
  logic [7:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_frame;

  logic        w_wr;
  logic [1:0]  w_reg;
  logic        w_wr_ctrl;
  logic        w_en_rise;
  logic        w_tick;
  state_t      w_nxt_state;
  logic [2:0]  w_nxt_digit;
  logic [3:0]  w_nxt_sub;
  logic        w_wrap;
  logic        w_lit;
  logic [6:0]  w_dec;
  logic        w_unused;

  assign w_unused  = ^i_wb_adr[1:0];
  assign w_reg     = i_wb_adr[3:2];
  assign w_wr      = i_wb_cyc & i_wb_stb & i_wb_we & ~r_ack;
  assign w_wr_ctrl = w_wr & (w_reg == REG_CTRL) & i_wb_sel[0];
  // EN 0->1 is seen on the write itself so shadows load from the staging
  // contents present at that moment.
  assign w_en_rise = w_wr_ctrl & i_wb_dat[0] & ~r_en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_en      <= 1'b0;
      r_bright  <= 4'hF;
      r_enables <= 8'h00;
      r_digits  <= 32'h0;
      r_div     <= DEFAULT_DIV;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= i_wb_dat[0];
        r_bright <= i_wb_dat[7:4];
      end
      if (w_wr && (w_reg == REG_ENABLES) && i_wb_sel[0]) begin
        r_enables <= i_wb_dat[7:0];
      end
      if (w_wr && (w_reg == REG_DIGITS)) begin
        for (int b = 0; b < 4; b++) begin
          if (i_wb_sel[b]) r_digits[8*b +: 8] <= i_wb_dat[8*b +: 8];
        end
      end
      if (w_wr && (w_reg == REG_DIV)) begin
        if (i_wb_sel[0]) r_div[7:0]  <= i_wb_dat[7:0];
        if (i_wb_sel[1]) r_div[15:8] <= i_wb_dat[15:8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack <= 1'b0;
      r_rdt <= 32'h0;
    end else begin
      r_ack <= i_wb_cyc & ~r_ack;
      case (w_reg)
        REG_CTRL:    r_rdt <= {24'h0, r_bright, 3'b000, r_en};
        REG_ENABLES: r_rdt <= {24'h0, r_enables};
        REG_DIGITS:  r_rdt <= r_digits;
        default:     r_rdt <= {16'h0, r_div};
      endcase
    end
  end

  // Prescaler is held at DIV while disabled so the first tick after enable
  // lands a full period later; a DIV write is picked up at the next reload.
  assign w_tick = (r_presc == 16'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= DEFAULT_DIV;
    end else if (!r_en || w_tick) begin
      r_presc <= r_div;
    end else begin
      r_presc <= r_presc - 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_digit <= 3'd0;
      r_sub   <= 4'd0;
    end else begin
      r_state <= w_nxt_state;
      r_digit <= w_nxt_digit;
      r_sub   <= w_nxt_sub;
    end
  end

  // Disable wins over any tick in the same clock.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_digit = r_digit;
    w_nxt_sub   = r_sub;
    w_wrap      = 1'b0;
    if (!r_en) begin
      w_nxt_state = ST_IDLE;
      w_nxt_digit = 3'd0;
      w_nxt_sub   = 4'd0;
    end else if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          w_nxt_state = ST_BLANK;
          w_nxt_digit = 3'd0;
          w_nxt_sub   = 4'd0;
        end
        ST_BLANK: begin
          w_nxt_state = ST_ON;
          w_nxt_sub   = 4'd1;
        end
        ST_ON: begin
          if (r_sub == LAST_SUB) begin
            w_nxt_state = ST_BLANK;
            w_nxt_sub   = 4'd0;
            w_nxt_digit = r_digit + 3'd1;
            w_wrap      = (r_digit == LAST_DIGIT);
          end else begin
            w_nxt_sub = r_sub + 4'd1;
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_digit = 3'd0;
          w_nxt_sub   = 4'd0;
        end
      endcase
    end
  end

  // Nonblocking copy: a staging write in the wrap clock lands one frame later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh_en  <= 8'h00;
      r_sh_dig <= 32'h0;
    end else if (w_wrap || w_en_rise) begin
      r_sh_en  <= r_enables;
      r_sh_dig <= r_digits;
    end
  end

  sevseg_hex_dec u_hex_dec (
    .i_val (r_sh_dig[{r_digit, 2'b00} +: 4]),
    .o_seg (w_dec)
  );

  // sub runs 1..15 in ON, so BRIGHT=0 never lights and BRIGHT=15 lights all of ON.
  assign w_lit = (r_state == ST_ON) & r_sh_en[r_digit] & (r_sub <= r_bright);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_an    <= 8'hFF;
      r_seg   <= 7'h7F;
      r_frame <= 1'b0;
    end else begin
      r_an    <= w_lit ? ~(8'h01 << r_digit) : 8'hFF;
      r_seg   <= w_lit ? w_dec : 7'h7F;
      r_frame <= w_wrap;
    end
  end

  assign o_wb_ack = r_ack;
  assign o_wb_rdt = r_rdt;
  assign o_an     = r_an;
  assign o_seg    = r_seg;
  assign o_frame  = r_frame;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// tb/tb_sevseg_scan_ctrl.sv - directed self-checking bench for sevseg_scan_ctrl
`timescale 1ns/1ps
module tb_sevseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  wb_adr = 4'h0;
  logic [31:0] wb_dat = 32'h0;
  logic [3:0]  wb_sel = 4'h0;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sevseg_scan_ctrl #(.DEFAULT_DIV(16'd999)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wb_adr (wb_adr),
    .i_wb_dat (wb_dat),
    .i_wb_sel (wb_sel),
    .i_wb_we  (wb_we),
    .i_wb_cyc (wb_cyc),
    .i_wb_stb (wb_stb),
    .o_wb_rdt (wb_rdt),
    .o_wb_ack (wb_ack),
    .o_an     (an),
    .o_seg    (seg),
    .o_frame  (frame)
  );

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Expected anodes k clocks after the enabling write edge (one tick per clock):
  // k=1 idle, then 16-clock slots starting at k=2, first clock of each slot blank.
  function automatic logic [7:0] exp_an(input int k, input logic [7:0] ens, input logic [3:0] br);
    int pos;
    int d;
    if (k < 2) return 8'hFF;
    pos = (k - 2) % 16;
    d   = ((k - 2) / 16) % 8;
    if (pos == 0 || pos > int'(br) || !ens[d]) return 8'hFF;
    return ~(8'h01 << d);
  endfunction

  function automatic int exp_digit(input int k);
    if (k < 2) return 0;
    return ((k - 2) / 16) % 8;
  endfunction

  task automatic bus_drive(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input logic we);
    wb_adr = a; wb_dat = d; wb_sel = s; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
  endtask

  task automatic bus_idle();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1; bus_drive(a, d, s, 1'b1);
    @(posedge clk); #1; bus_idle();
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] d, output logic ack);
    @(posedge clk); #1; bus_drive(a, 32'h0, 4'hF, 1'b0);
    @(posedge clk); #1; d = wb_rdt; ack = wb_ack; bus_idle();
  endtask

  task automatic start_scan(input logic [15:0] div, input logic [7:0] ens, input logic [31:0] digs, input logic [31:0] ctrl);
    wb_write(4'h0, 32'h0, 4'hF);
    wb_write(4'hC, {16'h0, div}, 4'hF);
    wb_write(4'h4, {24'h0, ens}, 4'hF);
    wb_write(4'h8, digs, 4'hF);
    wb_write(4'h0, ctrl, 4'hF);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        a;
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h000000F0; exp_rd[1] = 32'h0; exp_rd[2] = 32'h0; exp_rd[3] = 32'd999;
    rst = 1'b1; bus_idle();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (an !== 8'hFF) begin n_err++; $display("FAIL reset_an got %h want ff", an); end
    n_vec++; if (seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %h want 7f", seg); end
    n_vec++; if (frame !== 1'b0) begin n_err++; $display("FAIL reset_frame got %b want 0", frame); end
    n_vec++; if (wb_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", wb_ack); end
    n_vec++; if (wb_rdt !== 32'h0) begin n_err++; $display("FAIL reset_rdt got %h want 0", wb_rdt); end
    @(negedge clk); rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      wb_read(4'(r * 4), d, a);
      n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL reset_read_ack reg%0d got %b want 1", r, a); end
      n_vec++; if (d !== exp_rd[r]) begin n_err++; $display("FAIL reset_read reg%0d got %h want %h", r, d, exp_rd[r]); end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic        a;
    wb_write(4'h8, 32'h12345678, 4'hF);
    wb_write(4'h8, 32'hAABBCCDD, 4'b0101);
    wb_read(4'h8, d, a);
    n_vec++; if (d !== 32'h12BB56DD) begin n_err++; $display("FAIL lanes_digits got %h want 12bb56dd", d); end
    wb_write(4'hC, 32'hFFFFABCD, 4'b0011);
    wb_read(4'hC, d, a);
    n_vec++; if (d !== 32'h0000ABCD) begin n_err++; $display("FAIL div_rw got %h want 0000abcd", d); end
    wb_write(4'h4, 32'hFFFFFF5A, 4'hF);
    wb_read(4'h4, d, a);
    n_vec++; if (d !== 32'h0000005A) begin n_err++; $display("FAIL enables_rw got %h want 5a", d); end
    wb_write(4'h0, 32'hFFFFFF3E, 4'hF);
    wb_write(4'h0, 32'hFFFFFFFF, 4'h0);
    wb_read(4'h0, d, a);
    n_vec++; if (d !== 32'h00000030) begin n_err++; $display("FAIL ctrl_rw got %h want 30", d); end
  endtask

  task automatic test_full_bright();
    logic [7:0]  ea;
    logic [6:0]  es;
    logic [31:0] digs;
    digs = 32'h76543210;
    start_scan(16'd0, 8'hFF, digs, 32'hF1);
    for (int c = 1; c <= 260; c++) begin
      @(posedge clk); #1;
      ea = exp_an(c, 8'hFF, 4'hF);
      es = (ea == 8'hFF) ? 7'h7F : hex7(digs[4*exp_digit(c) +: 4]);
      n_vec++; if (an !== ea) begin n_err++; $display("FAIL full_an c=%0d got %h want %h", c, an, ea); end
      n_vec++; if (seg !== es) begin n_err++; $display("FAIL full_seg c=%0d got %h want %h", c, seg, es); end
      n_vec++; if (frame !== (c == 129 || c == 257)) begin n_err++; $display("FAIL full_frame c=%0d got %b", c, frame); end
    end
  endtask

  task automatic test_dimmed();
    int cnt [8];
    logic [7:0] ea;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    start_scan(16'd0, 8'h05, 32'h76543210, 32'h41);
    for (int c = 1; c <= 129; c++) begin
      @(posedge clk); #1;
      ea = exp_an(c, 8'h05, 4'h4);
      n_vec++; if (an !== ea) begin n_err++; $display("FAIL dim_an c=%0d got %h want %h", c, an, ea); end
      for (int i = 0; i < 8; i++) if (an[i] === 1'b0) cnt[i]++;
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (cnt[i] != ((i == 0 || i == 2) ? 4 : 0)) begin
        n_err++; $display("FAIL dim_count digit%0d got %0d want %0d", i, cnt[i], (i == 0 || i == 2) ? 4 : 0);
      end
    end
  endtask

  // Mid-frame DIGITS write shows next frame; a write on the wrap edge shows a frame later.
  task automatic test_tear_free();
    logic [7:0]  ea;
    logic [6:0]  es;
    logic [31:0] shown;
    int f;
    start_scan(16'd0, 8'hFF, 32'h76543210, 32'hF1);
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      f = (c < 2) ? 0 : (c - 2) / 128;
      shown = (f == 0) ? 32'h76543210 : ((f == 1) ? 32'h88888888 : 32'hFEDCBA98);
      ea = exp_an(c, 8'hFF, 4'hF);
      es = (ea == 8'hFF) ? 7'h7F : hex7(shown[4*exp_digit(c) +: 4]);
      n_vec++; if (an !== ea) begin n_err++; $display("FAIL tear_an c=%0d got %h want %h", c, an, ea); end
      n_vec++; if (seg !== es) begin n_err++; $display("FAIL tear_seg c=%0d got %h want %h", c, seg, es); end
      n_vec++; if (frame !== (c == 129 || c == 257)) begin n_err++; $display("FAIL tear_frame c=%0d got %b", c, frame); end
      if (c == 40) bus_drive(4'h8, 32'h88888888, 4'hF, 1'b1);
      if (c == 41) bus_idle();
      if (c == 128) bus_drive(4'h8, 32'hFEDCBA98, 4'hF, 1'b1);
      if (c == 129) bus_idle();
    end
  endtask

  task automatic test_disable();
    logic [7:0]  ea;
    logic [6:0]  es;
    logic [31:0] digs;
    int k;
    digs = 32'h76543210;
    start_scan(16'd0, 8'hFF, digs, 32'hF1);
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (c <= 22) k = c;
      else if (c <= 41) k = 0;
      else k = c - 41;
      ea = exp_an(k, 8'hFF, 4'hF);
      es = (ea == 8'hFF) ? 7'h7F : hex7(digs[4*exp_digit(k) +: 4]);
      n_vec++; if (an !== ea) begin n_err++; $display("FAIL dis_an c=%0d got %h want %h", c, an, ea); end
      n_vec++; if (seg !== es) begin n_err++; $display("FAIL dis_seg c=%0d got %h want %h", c, seg, es); end
      if (c == 20) bus_drive(4'h0, 32'hF0, 4'hF, 1'b1);
      if (c == 21) bus_idle();
      if (c == 40) bus_drive(4'h0, 32'hF1, 4'hF, 1'b1);
      if (c == 41) bus_idle();
    end
  endtask

  task automatic test_prescaler_reset();
    logic [7:0]  ea;
    logic [31:0] d;
    logic        a;
    int lit0;
    lit0 = 0;
    start_scan(16'd3, 8'h03, 32'h76543210, 32'hF1);
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      ea = exp_an(((c - 1) / 4) + 1, 8'h03, 4'hF);
      n_vec++; if (an !== ea) begin n_err++; $display("FAIL div_an c=%0d got %h want %h", c, an, ea); end
      if (an === 8'hFE) lit0++;
    end
    n_vec++; if (lit0 != 60) begin n_err++; $display("FAIL div_slot_len got %0d want 60", lit0); end
    n_vec++; if (an !== 8'hFD) begin n_err++; $display("FAIL pre_reset_an got %h want fd", an); end
    #2; rst = 1'b1; #1;
    n_vec++; if (an !== 8'hFF) begin n_err++; $display("FAIL async_reset_an got %h want ff", an); end
    n_vec++; if (seg !== 7'h7F) begin n_err++; $display("FAIL async_reset_seg got %h want 7f", seg); end
    @(negedge clk); rst = 1'b0;
    wb_read(4'hC, d, a);
    n_vec++; if (d !== 32'd999) begin n_err++; $display("FAIL reset_div_restore got %h want 3e7", d); end
    wb_read(4'h0, d, a);
    n_vec++; if (d !== 32'hF0) begin n_err++; $display("FAIL reset_ctrl_restore got %h want f0", d); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (an !== 8'hFF) begin n_err++; $display("FAIL post_reset_idle got %h want ff", an); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_full_bright();
    test_dimmed();
    test_tear_free();
    test_disable();
    test_prescaler_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
